// File: rtl/track_sequencer_pkg.sv
// Shared definitions for the track sequencer: loop-mode codes, the playback
// FSM encoding and the seconds-to-address-step conversion.
package track_sequencer_pkg;

  // loop_mode codes; 2'b11 falls through to the LOOP_ALL behaviour
  localparam logic [1:0] LOOP_STOP = 2'b00;
  localparam logic [1:0] LOOP_ALL  = 2'b01;
  localparam logic [1:0] LOOP_ONE  = 2'b10;

  // state   | meaning
  // PAUSED  | position held, seeks still act
  // PLAYING | position advances on sample_en
  // LOAD    | one cycle: addr <= 0, track_start pulse, back to play state
  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    LOAD    = 2'd2
  } state_t;

  function automatic int sec_to_step(input int seconds, input int samples_per_sec);
    return seconds * samples_per_sec;
  endfunction

endpackage

// File: rtl/track_sequencer_edge_pulse.sv
// Registered rising-edge detector for a level button.
// Ports: clk, rst_n (async active-low), i_level (button level),
//        o_pulse (high for the cycle in which i_level is first seen high).
// r_arm stays low for the first clock after reset so a button that was held
// through reset is absorbed into the history instead of firing.
module track_sequencer_edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;
  logic r_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= i_level;
      r_arm  <= 1'b1;
    end
  end

  assign o_pulse = i_level & ~r_prev & r_arm;

endmodule

// File: rtl/track_sequencer.sv
// Playback position owner for TRACKS tracks sharing one ROM.
// Handles play/pause, per-sample address stepping, short/long seeks,
// next/prev (with restart window), end-of-track detection and loop modes.
// Ports:
//   clk, reset (async active-low), sample_en (step strobe)
//   play_pause/next/prev/fwd_short/back_short/fwd_long/back_long (level buttons)
//   loop_mode (00 stop, 01 wrap, 10 repeat one, 11 wrap)
//   rom_data (word at rom_addr), rom_addr = {track_sel, addr}
//   playing, track_start/time_adj/list_end (1-cycle pulses), time_adder (signed s)
module track_sequencer
  import track_sequencer_pkg::*;
#(
  parameter int TRACKS          = 4,
  parameter int ADDR_W          = 22,
  parameter int DATA_W          = 8,
  parameter logic [DATA_W-1:0] END_WORD = '1,
  parameter int SAMPLES_PER_SEC = 8000,
  parameter int SEEK_SHORT_S    = 10,
  parameter int SEEK_LONG_S     = 30,
  parameter int PREV_RESTART_S  = 3,
  localparam int SEL_W          = (TRACKS > 1) ? $clog2(TRACKS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic                    play_pause,
  input  logic                    next,
  input  logic                    prev,
  input  logic                    fwd_short,
  input  logic                    back_short,
  input  logic                    fwd_long,
  input  logic                    back_long,
  input  logic [1:0]              loop_mode,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [SEL_W+ADDR_W-1:0] rom_addr,
  output logic [SEL_W-1:0]        track_sel,
  output logic                    playing,
  output logic                    track_start,
  output logic                    time_adj,
  output logic signed [8:0]       time_adder,
  output logic                    list_end
);

  localparam logic [ADDR_W:0]   STEP_SHORT   = (ADDR_W+1)'(sec_to_step(SEEK_SHORT_S, SAMPLES_PER_SEC));
  localparam logic [ADDR_W:0]   STEP_LONG    = (ADDR_W+1)'(sec_to_step(SEEK_LONG_S, SAMPLES_PER_SEC));
  localparam logic [ADDR_W:0]   STEP_RESTART = (ADDR_W+1)'(sec_to_step(PREV_RESTART_S, SAMPLES_PER_SEC));
  localparam logic [ADDR_W-1:0] STEP_SHORT_L = STEP_SHORT[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] STEP_LONG_L  = STEP_LONG[ADDR_W-1:0];
  localparam logic [SEL_W-1:0]  LAST_TRACK   = SEL_W'(TRACKS - 1);
  localparam logic signed [8:0] ADJ_SHORT    = 9'(SEEK_SHORT_S);
  localparam logic signed [8:0] ADJ_LONG     = 9'(SEEK_LONG_S);

  state_t                r_state, w_state_nxt;
  logic                  r_play, w_play_nxt;
  logic [SEL_W-1:0]      r_track, w_track_nxt;
  logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
  logic                  r_track_start, w_track_start_nxt;
  logic                  r_time_adj, w_time_adj_nxt;
  logic signed [8:0]     r_time_adder, w_time_adder_nxt;
  logic                  r_list_end, w_list_end_nxt;

  logic [6:0]            w_btn;
  logic [6:0]            w_edge;
  logic                  w_pp, w_nx, w_pv, w_fl, w_bl, w_fs, w_bs;
  logic                  w_load;
  logic                  w_end_play;
  logic [ADDR_W:0]       w_addr_ext;
  logic [ADDR_W:0]       w_sum_short, w_sum_long;
  logic [SEL_W-1:0]      w_track_inc, w_track_dec;
  logic [SEL_W-1:0]      w_end_track;
  logic                  w_end_stop;

  assign w_btn = {back_short, fwd_short, back_long, fwd_long, prev, next, play_pause};

  for (genvar g = 0; g < 7; g++) begin : g_edge
    track_sequencer_edge_pulse u_edge (
      .clk     (clk),
      .rst_n   (reset),
      .i_level (w_btn[g]),
      .o_pulse (w_edge[g])
    );
  end

  assign {w_bs, w_fs, w_bl, w_fl, w_pv, w_nx, w_pp} = w_edge;

  assign w_addr_ext  = {1'b0, r_addr};
  assign w_sum_short = w_addr_ext + STEP_SHORT;
  assign w_sum_long  = w_addr_ext + STEP_LONG;
  assign w_track_inc = (r_track == LAST_TRACK) ? '0 : r_track + SEL_W'(1);
  assign w_track_dec = (r_track == '0) ? LAST_TRACK : r_track - SEL_W'(1);
  assign w_end_play  = (r_state == PLAYING) &&
                       ((rom_data == END_WORD) || (r_addr == {ADDR_W{1'b1}}));

  // Destination for an end event (sentinel, last address or forward-seek overflow)
  always_comb begin
    w_end_track = w_track_inc;
    w_end_stop  = 1'b0;
    case (loop_mode)
      LOOP_ONE:  w_end_track = r_track;
      LOOP_STOP: if (r_track == LAST_TRACK) begin
                   w_end_track = '0;
                   w_end_stop  = 1'b1;
                 end
      default:   w_end_track = w_track_inc;
    endcase
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_play_nxt        = r_play;
    w_track_nxt       = r_track;
    w_addr_nxt        = r_addr;
    w_track_start_nxt = 1'b0;
    w_time_adj_nxt    = 1'b0;
    w_time_adder_nxt  = r_time_adder;
    w_list_end_nxt    = 1'b0;
    w_load            = 1'b0;

    if (r_state == LOAD) begin
      // every button edge seen during LOAD is discarded
      w_addr_nxt        = '0;
      w_track_start_nxt = 1'b1;
      w_state_nxt       = r_play ? PLAYING : PAUSED;
    end else begin
      w_play_nxt = r_play ^ w_pp;
      if (w_end_play || (w_fl && w_sum_long[ADDR_W] && !w_nx && !w_pv) ||
          (w_fs && w_sum_short[ADDR_W] && !w_nx && !w_pv && !w_fl && !w_bl)) begin
        w_load      = 1'b1;
        w_track_nxt = w_end_track;
        if (w_end_stop) begin
          w_play_nxt     = 1'b0;
          w_list_end_nxt = 1'b1;
        end
      end else if (w_nx) begin
        w_load      = 1'b1;
        w_track_nxt = w_track_inc;
      end else if (w_pv) begin
        w_load = 1'b1;
        if (w_addr_ext < STEP_RESTART &&
            !(loop_mode == LOOP_STOP && r_track == '0))
          w_track_nxt = w_track_dec;
      end else if (w_fl) begin
        w_addr_nxt       = w_sum_long[ADDR_W-1:0];
        w_time_adder_nxt = ADJ_LONG;
        w_time_adj_nxt   = 1'b1;
      end else if (w_bl) begin
        if (w_addr_ext >= STEP_LONG) begin
          w_addr_nxt       = r_addr - STEP_LONG_L;
          w_time_adder_nxt = -ADJ_LONG;
          w_time_adj_nxt   = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end else if (w_fs) begin
        w_addr_nxt       = w_sum_short[ADDR_W-1:0];
        w_time_adder_nxt = ADJ_SHORT;
        w_time_adj_nxt   = 1'b1;
      end else if (w_bs) begin
        if (w_addr_ext >= STEP_SHORT) begin
          w_addr_nxt       = r_addr - STEP_SHORT_L;
          w_time_adder_nxt = -ADJ_SHORT;
          w_time_adj_nxt   = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end else if (r_state == PLAYING && sample_en && !w_pp) begin
        w_addr_nxt = r_addr + ADDR_W'(1);
      end

      if (w_load) w_state_nxt = LOAD;
      else        w_state_nxt = w_play_nxt ? PLAYING : PAUSED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= PAUSED;
      r_play        <= 1'b0;
      r_track       <= '0;
      r_addr        <= '0;
      r_track_start <= 1'b0;
      r_time_adj    <= 1'b0;
      r_time_adder  <= '0;
      r_list_end    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_play        <= w_play_nxt;
      r_track       <= w_track_nxt;
      r_addr        <= w_addr_nxt;
      r_track_start <= w_track_start_nxt;
      r_time_adj    <= w_time_adj_nxt;
      r_time_adder  <= w_time_adder_nxt;
      r_list_end    <= w_list_end_nxt;
    end
  end

  assign rom_addr    = {r_track, r_addr};
  assign track_sel   = r_track;
  assign playing     = r_play;
  assign track_start = r_track_start;
  assign time_adj    = r_time_adj;
  assign time_adder  = r_time_adder;
  assign list_end    = r_list_end;

endmodule

// File: tb/tb_track_sequencer.sv
// Directed bench for track_sequencer: TRACKS=3, ADDR_W=8, SAMPLES_PER_SEC=4
// (short seek 40, long seek 120, prev restart window 12 addresses).
module tb_track_sequencer;

  localparam logic [6:0] B_PP = 7'b0000001;
  localparam logic [6:0] B_NX = 7'b0000010;
  localparam logic [6:0] B_PV = 7'b0000100;
  localparam logic [6:0] B_FL = 7'b0001000;
  localparam logic [6:0] B_BL = 7'b0010000;
  localparam logic [6:0] B_FS = 7'b0100000;
  localparam logic [6:0] B_BS = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [6:0]  btn;
  logic [1:0]  loop_mode;
  logic [7:0]  rom_data;
  logic [9:0]  rom_addr;
  logic [1:0]  track_sel;
  logic        playing;
  logic        track_start;
  logic        time_adj;
  logic signed [8:0] time_adder;
  logic        list_end;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  track_sequencer #(
    .TRACKS(3),
    .ADDR_W(8),
    .DATA_W(8),
    .SAMPLES_PER_SEC(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .play_pause (btn[0]),
    .next       (btn[1]),
    .prev       (btn[2]),
    .fwd_long   (btn[3]),
    .back_long  (btn[4]),
    .fwd_short  (btn[5]),
    .back_short (btn[6]),
    .loop_mode  (loop_mode),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .track_sel  (track_sel),
    .playing    (playing),
    .track_start(track_start),
    .time_adj   (time_adj),
    .time_adder (time_adder),
    .list_end   (list_end)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [6:0] m);
    btn = m;
    tick();
    btn = '0;
  endtask

  task automatic run(input int n);
    sample_en = 1'b1;
    repeat (n) tick();
    sample_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sample_en = 1'b1; btn = '0; loop_mode = 2'b01; rom_data = 8'h00;
    #2;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_play", 32'(playing), 32'd0);
    chk("rst_pulses", 32'({track_start, time_adj, list_end}), 32'd0);
    chk("rst_adder", 32'(time_adder), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // play, 20 samples
    press(B_PP);
    repeat (20) tick();
    sample_en = 1'b0;
    chk("t1_play", 32'(playing), 32'd1);
    chk("t1_addr", 32'(rom_addr), 32'd20);

    // short forward seek, then long back below start
    press(B_FS);
    chk("t2_fs_addr", 32'(rom_addr), 32'd60);
    chk("t2_fs_adj", 32'(time_adj), 32'd1);
    chk("t2_fs_adder", 32'($signed(time_adder)), 32'd10);
    tick();
    chk("t2_adj_once", 32'(time_adj), 32'd0);
    press(B_BL);
    chk("t2_bl_noadj", 32'(time_adj), 32'd0);
    tick();
    chk("t2_bl_addr", 32'(rom_addr), 32'd0);
    chk("t2_bl_ts", 32'(track_start), 32'd1);
    tick();
    chk("t2_ts_once", 32'(track_start), 32'd0);

    // prev inside / outside restart window
    press(B_NX); tick();
    chk("t3_trk1", 32'(track_sel), 32'd1);
    run(5);
    chk("t3_addr5", 32'(rom_addr), 32'd261);
    press(B_PV);
    chk("t3_prev_trk", 32'(track_sel), 32'd0);
    tick();
    chk("t3_prev_ts", 32'(track_start), 32'd1);
    press(B_NX); tick();
    run(20);
    press(B_PV);
    tick();
    chk("t3_restart", 32'(rom_addr), 32'd256);
    chk("t3_restart_ts", 32'(track_start), 32'd1);

    // wrap backwards and forwards across a non-power-of-two count
    press(B_PV); tick();
    press(B_PV);
    chk("t3_prev_wrap", 32'(track_sel), 32'd2);
    tick();
    press(B_NX);
    chk("t3_next_wrap", 32'(track_sel), 32'd0);
    tick();
    // edge during LOAD is discarded
    press(B_NX);
    press(B_FS);
    chk("load_drop_adj", 32'(time_adj), 32'd0);
    tick();
    chk("load_drop_addr", 32'(rom_addr), 32'd256);
    press(B_NX); tick();

    // end of track, stop mode on last track
    loop_mode = 2'b00; rom_data = 8'hFF;
    tick();
    rom_data = 8'h00;
    chk("t4_stop_trk", 32'(track_sel), 32'd0);
    chk("t4_stop_play", 32'(playing), 32'd0);
    chk("t4_stop_le", 32'(list_end), 32'd1);
    tick();
    chk("t4_le_once", 32'(list_end), 32'd0);

    // wrap mode
    press(B_PP);
    press(B_NX); tick();
    press(B_NX); tick();
    loop_mode = 2'b01; rom_data = 8'hFF;
    tick();
    rom_data = 8'h00;
    chk("t4_all_trk", 32'(track_sel), 32'd0);
    chk("t4_all_play", 32'(playing), 32'd1);
    chk("t4_all_le", 32'(list_end), 32'd0);
    tick();

    // repeat-one mode
    press(B_NX); tick();
    press(B_NX); tick();
    run(3);
    loop_mode = 2'b10; rom_data = 8'hFF;
    tick();
    rom_data = 8'h00;
    chk("t4_one_trk", 32'(track_sel), 32'd2);
    tick();
    chk("t4_one_addr", 32'(rom_addr), 32'd512);

    // next beats fwd_long; fwd_long past the end acts as end of track
    loop_mode = 2'b01;
    press(B_NX | B_FL);
    chk("t5_prio_trk", 32'(track_sel), 32'd0);
    chk("t5_prio_adj", 32'(time_adj), 32'd0);
    tick();
    chk("t5_adder_hold", 32'($signed(time_adder)), 32'd10);
    run(230);
    chk("t5_addr230", 32'(rom_addr), 32'd230);
    press(B_FL);
    chk("t5_ovf_trk", 32'(track_sel), 32'd1);
    chk("t5_ovf_adj", 32'(time_adj), 32'd0);
    tick();
    chk("t5_ovf_addr", 32'(rom_addr), 32'd256);

    // short backward seek
    run(50);
    press(B_BS);
    chk("bs_addr", 32'(rom_addr), 32'd266);
    chk("bs_adder", 32'($signed(time_adder)), -32'sd10);
    chk("bs_adj", 32'(time_adj), 32'd1);

    // async reset mid-play, play_pause held through release
    run(67);
    chk("t6_addr77", 32'(rom_addr), 32'd333);
    reset = 1'b0; btn = B_PP;
    #1;
    chk("t6_rst_addr", 32'(rom_addr), 32'd0);
    chk("t6_rst_play", 32'(playing), 32'd0);
    #2;
    reset = 1'b1;
    repeat (3) tick();
    chk("t6_held_pp", 32'(playing), 32'd0);
    btn = '0;
    tick();
    press(B_PP);
    chk("t6_pp_after", 32'(playing), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/track_sequencer.md
Name: track_sequencer

Overview:
Parametrised successor to the fixed 4-track address/track-select pair. Owns the playback position for TRACKS tracks of one shared ROM: play/pause, sample-rate address stepping, ±short/±long seek, next/prev with restart rule, end-of-track sentinel detection and loop modes. Drives the ROM address and feeds the seconds timer (track_start, time_adder/time_adj).

Parameters:
TRACKS, 4, number of tracks; SEL_W = clog2(TRACKS), minimum 1
ADDR_W, 22, per-track address width
DATA_W, 8, ROM word width
END_WORD, all-ones, sentinel word marking end of track
SAMPLES_PER_SEC, 8000, address increments per second of audio
SEEK_SHORT_S, 10, short seek in seconds
SEEK_LONG_S, 30, long seek in seconds
PREV_RESTART_S, 3, prev inside this window goes to the previous track, otherwise restarts the current one

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_en  in  1  one-cycle strobe; address advances on it while playing
play_pause, next, prev  in  1 each  level buttons, rising-edge detected internally
fwd_short, back_short, fwd_long, back_long  in  1 each  level seek buttons, rising-edge detected
loop_mode  in  2  00 stop at end of list, 01 wrap list, 10 repeat one, 11 treated as 01
rom_data  in  DATA_W  combinational ROM word at rom_addr
rom_addr  out  SEL_W+ADDR_W  {track_sel, addr}
track_sel  out  SEL_W  current track
playing  out  1  1 = play
track_start  out  1  one-cycle pulse: position reset to 0 (timer reset)
time_adj  out  1  one-cycle pulse: time_adder valid
time_adder  out  9 signed  seconds applied by the seek (±SEEK_SHORT_S / ±SEEK_LONG_S)
list_end  out  1  one-cycle pulse: list finished in mode 00

Behaviour:
- Reset (async, reset=0): addr=0, track_sel=0, playing=0, all pulses 0, time_adder=0, edge-detector history cleared to 0 (a button held through reset does not fire).
- Inputs are registered once for edge detection; an action takes effect on the clock after the input rises. Output pulses are registered: high for exactly one cycle.
- FSM states: PAUSED, PLAYING, LOAD. PLAYING and PAUSED toggle on a play_pause edge. LOAD is one cycle long: it zeroes addr, pulses track_start, then returns to the previous play state.
- Stepping: in PLAYING with sample_en=1, addr += 1. Stepping is suppressed in any cycle that has a button action, and in LOAD.
- End of track: in PLAYING, rom_data == END_WORD, or addr reaching 2^ADDR_W-1, raises an end event. Track choice on the end event:
  - mode 10: same track.
  - mode 01/11: (track_sel+1) mod TRACKS.
  - mode 00, last track: track 0, playing=0, list_end pulse.
  - mode 00, other tracks: next track.
  - In every case the block enters LOAD.
- next: (track_sel+1) mod TRACKS in all modes, then LOAD. Play state is kept.
- prev: if addr >= PREV_RESTART_S*SAMPLES_PER_SEC, restart the current track. Otherwise go to (track_sel-1) mod TRACKS. In mode 00 at track 0, restart track 0. Then LOAD.
- Seek, with S = seek seconds * SAMPLES_PER_SEC:
  - Forward: if addr+S overflows ADDR_W, handle as an end event. Otherwise addr += S, time_adder=+s, time_adj pulse.
  - Backward: if addr >= S, addr -= S, time_adder=-s, time_adj pulse. Otherwise LOAD on the same track (track_start pulse, no time_adj).
  - Seeks act in both PAUSED and PLAYING.
- Arithmetic is done at ADDR_W+1 bits so overflow can be detected. time_adder holds its last value between pulses.
- Simultaneous edges, priority: end event > next > prev > fwd_long > back_long > fwd_short > back_short. Lower-priority edges in the same cycle are dropped. play_pause is independent and is applied in the same cycle as any of them.
- Edges arriving while in LOAD are dropped.
- TRACKS not a power of two: track_sel wraps at TRACKS-1, never exceeds it.

Decomposition:
- Shared package:
  - loop-mode constants LOOP_STOP/LOOP_ALL/LOOP_ONE
  - state encoding PAUSED/PLAYING/LOAD
  - a function converting seconds to an address step
- Natural sub-module: edge_pulse (registered rising-edge detector, async active-low reset), instantiated seven times.

Test Plan:
1. Bench parameters ADDR_W=8, SAMPLES_PER_SEC=4, TRACKS=3, sample_en every cycle. Press play_pause, wait 20 cycles -> playing=1, addr=20, rom_addr={2'd0,8'd20}.
2. At addr=20, fwd_short -> addr=60, time_adder=+10, one time_adj pulse. back_long -> addr=0, track_start pulse, no time_adj.
3. addr=5, press prev on track 1 -> track_sel=0 with track_start pulse. Repeat with addr=20 -> track_sel stays 1, addr=0.
4. rom_data=END_WORD on track 2 in mode 00 -> track_sel=0, playing=0, list_end pulse. Same in mode 01 -> track_sel=0, playing=1. Mode 10 -> track_sel=2, addr=0.
5. next and fwd_long rise in the same cycle -> only the track change occurs, no time_adj. addr=230 with fwd_long -> treated as end of track.
6. Assert reset for one half-cycle while playing at addr=77, track 1 -> all outputs 0 immediately. Holding play_pause through the release produces no toggle.
